// File: rtl/ascii_num_parser_if.sv
// ascii_num_parser_if
//   Character-in / number-out handshake bundle for ascii_num_parser.
//   Ports (slave = parser side):
//     char_in[7:0], char_valid  -> parser ; char_rdy <- parser
//     num_out, term_out, err_empty, err_ovf, num_valid <- parser ; num_rdy -> parser
//   master = the byte source / result consumer side.
interface ascii_num_parser_if #(
  parameter int NUM_BITS = 16
) ();
  logic [7:0]          char_in;
  logic                char_valid;
  logic                char_rdy;
  logic [NUM_BITS-1:0] num_out;
  logic [7:0]          term_out;
  logic                err_empty;
  logic                err_ovf;
  logic                num_valid;
  logic                num_rdy;

  modport master (
    output char_in, char_valid, num_rdy,
    input  char_rdy, num_out, term_out, err_empty, err_ovf, num_valid
  );

  modport slave (
    input  char_in, char_valid, num_rdy,
    output char_rdy, num_out, term_out, err_empty, err_ovf, num_valid
  );
endinterface

// File: rtl/ascii_num_parser.sv
// ascii_num_parser
//   Streaming decimal-number parser. Accepts one ASCII char per handshake,
//   accumulates an optionally signed decimal magnitude and presents it as a
//   two's-complement NUM_BITS word once a non-digit terminator arrives.
//   Out-of-range magnitudes saturate and flag err_ovf; a terminator without
//   any digit flags err_empty and yields 0.
//   Ports:
//     clk   - sole clock, rising edge
//     reset - synchronous, active-high
//     bus   - ascii_num_parser_if.slave (char stream in, result out)
module ascii_num_parser #(
  parameter int NUM_BITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  ascii_num_parser_if.slave  bus
);

  localparam int W = NUM_BITS + 5;
  localparam logic [NUM_BITS:0] LIM_NEG = (NUM_BITS+1)'(1) << (NUM_BITS - 1);
  localparam logic [NUM_BITS:0] LIM_POS = LIM_NEG - (NUM_BITS+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [NUM_BITS:0] acc_reg, acc_next;
  logic              neg_reg, neg_next;
  logic              seen_reg, seen_next;
  logic              ovf_reg, ovf_next;
  logic              empty_reg, empty_next;
  logic [7:0]        term_reg, term_next;

  logic              is_digit;
  logic [3:0]        digit;
  logic [W-1:0]      acc_ext;
  logic [W-1:0]      prod_next;
  logic [NUM_BITS:0] lim;
  logic [NUM_BITS:0] signed_val;

  assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  // XOR with 0x30 leaves the low nibble untouched, so the digit is just [3:0].
  assign digit    = bus.char_in[3:0];

  // acc*10 + digit in the wide domain so the overflow test cannot wrap.
  assign acc_ext   = W'(acc_reg);
  assign prod_next = (acc_ext << 3) + (acc_ext << 1) + W'(digit);
  assign lim       = neg_reg ? LIM_NEG : LIM_POS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      seen_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      empty_reg <= 1'b0;
      term_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      neg_reg   <= neg_next;
      seen_reg  <= seen_next;
      ovf_reg   <= ovf_next;
      empty_reg <= empty_next;
      term_reg  <= term_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    neg_next   = neg_reg;
    seen_next  = seen_reg;
    ovf_next   = ovf_reg;
    empty_next = empty_reg;
    term_next  = term_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.char_valid) begin
          if (bus.char_in == 8'h20) begin
            // leading blanks are swallowed
          end else if (bus.char_in == 8'h2D) begin
            neg_next   = 1'b1;
            state_next = ST_ACCUM;
          end else if (bus.char_in == 8'h2B) begin
            neg_next   = 1'b0;
            state_next = ST_ACCUM;
          end else if (is_digit) begin
            neg_next   = 1'b0;
            acc_next   = (NUM_BITS+1)'(digit);
            seen_next  = 1'b1;
            state_next = ST_ACCUM;
          end else begin
            term_next  = bus.char_in;
            empty_next = 1'b1;
            state_next = ST_DONE;
          end
        end
      end

      ST_ACCUM: begin
        if (bus.char_valid) begin
          if (is_digit) begin
            seen_next = 1'b1;
            // Once clamped, acc stays at the limit: limit*10+d always exceeds it.
            if (prod_next > W'(lim)) begin
              acc_next = lim;
              ovf_next = 1'b1;
            end else begin
              acc_next = prod_next[NUM_BITS:0];
            end
          end else begin
            term_next  = bus.char_in;
            empty_next = !seen_reg;
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.num_rdy) begin
          acc_next   = '0;
          neg_next   = 1'b0;
          seen_next  = 1'b0;
          ovf_next   = 1'b0;
          empty_next = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Negating LIM_NEG in NUM_BITS+1 bits truncates to the most negative word.
  assign signed_val = neg_reg ? (~acc_reg + (NUM_BITS+1)'(1)) : acc_reg;

  assign bus.num_out   = empty_reg ? '0 : signed_val[NUM_BITS-1:0];
  assign bus.term_out  = term_reg;
  assign bus.err_empty = empty_reg;
  assign bus.err_ovf   = ovf_reg;
  assign bus.num_valid = (state_reg == ST_DONE);
  assign bus.char_rdy  = (state_reg != ST_DONE) && !reset;

endmodule

// File: tb/tb_ascii_num_parser.sv
module tb_ascii_num_parser;

  logic clk;
  logic reset;

  ascii_num_parser_if #(.NUM_BITS(16)) bus ();

  ascii_num_parser #(.NUM_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] cur_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input string s);
    cur_q = {};
    for (int i = 0; i < s.len(); i++) cur_q.push_back(s[i]);
  endtask

  // Reference: walk the character list with plain integer arithmetic.
  task automatic model(output logic [15:0] val, output logic [7:0] term,
                       output logic e_empty, output logic e_ovf);
    bit      started = 0;
    bit      neg = 0;
    bit      seen = 0;
    longint  mag = 0;
    longint  limit;
    logic [7:0] c;
    term = 8'h00; e_empty = 0; e_ovf = 0;
    for (int i = 0; i < cur_q.size(); i++) begin
      c = cur_q[i];
      if (!started) begin
        if (c == 8'h20) continue;
        if (c == "-") begin neg = 1; started = 1; continue; end
        if (c == "+") begin started = 1; continue; end
        if (c >= "0" && c <= "9") begin
          started = 1; seen = 1; mag = longint'(c - 8'h30); continue;
        end
        term = c; e_empty = 1; break;
      end else begin
        if (c >= "0" && c <= "9") begin
          seen = 1;
          mag = mag * 10 + longint'(c - 8'h30);
          limit = neg ? 32768 : 32767;
          if (mag > limit) begin mag = limit; e_ovf = 1; end
        end else begin
          term = c; e_empty = !seen; break;
        end
      end
    end
    if (e_empty) val = 16'h0000;
    else val = 16'(neg ? -mag : mag);
  endtask

  // Stream cur_q with random idle gaps; every char must see char_rdy=1.
  task automatic send_q(input int gap_max);
    int gaps;
    for (int i = 0; i < cur_q.size(); i++) begin
      gaps = $urandom_range(gap_max, 0);
      for (int g = 0; g < gaps; g++) begin
        bus.char_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.char_valid = 1'b1;
      bus.char_in    = cur_q[i];
      check("char_rdy_during_stream", 32'(bus.char_rdy), 32'd1);
      @(posedge clk); #1;
    end
    bus.char_valid = 1'b0;
  endtask

  task automatic run_num(input string name, input int gap_max, input int hold);
    logic [15:0] e_val;
    logic [7:0]  e_term;
    logic        e_empty, e_ovf;
    model(e_val, e_term, e_empty, e_ovf);
    send_q(gap_max);
    // Result must be visible in the cycle right after the terminator edge.
    check({name, ":num_valid"}, 32'(bus.num_valid), 32'd1);
    check({name, ":num_out"},   32'(bus.num_out),   32'(e_val));
    check({name, ":term_out"},  32'(bus.term_out),  32'(e_term));
    check({name, ":err_empty"}, 32'(bus.err_empty), 32'(e_empty));
    check({name, ":err_ovf"},   32'(bus.err_ovf),   32'(e_ovf));
    check({name, ":char_rdy_done"}, 32'(bus.char_rdy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.num_rdy    = 1'b0;
      bus.char_valid = 1'b1;
      bus.char_in    = "9";
      @(posedge clk); #1;
      check({name, ":hold_valid"},    32'(bus.num_valid), 32'd1);
      check({name, ":hold_num"},      32'(bus.num_out),   32'(e_val));
      check({name, ":hold_term"},     32'(bus.term_out),  32'(e_term));
      check({name, ":hold_flags"},    32'({bus.err_empty, bus.err_ovf}), 32'({e_empty, e_ovf}));
      check({name, ":hold_char_rdy"}, 32'(bus.char_rdy),  32'd0);
    end
    bus.char_valid = 1'b0;
    bus.num_rdy    = 1'b1;
    @(posedge clk); #1;
    bus.num_rdy = 1'b0;
    check({name, ":valid_drop"},  32'(bus.num_valid), 32'd0);
    check({name, ":rdy_rise"},    32'(bus.char_rdy),  32'd1);
    check({name, ":cleared_num"}, 32'(bus.num_out),   32'd0);
    check({name, ":cleared_err"}, 32'({bus.err_empty, bus.err_ovf}), 32'd0);
    $display("num %s: got %h term %h empty %0d ovf %0d", name, e_val, e_term, e_empty, e_ovf);
  endtask

  task automatic gen_random();
    int nsp, nd, sgn;
    logic [7:0] tset[6];
    logic [7:0] eset[5];
    tset = '{8'h20, ",", 8'h0A, "X", "+", "-"};
    eset = '{",", "X", "G", ";", 8'h0A};
    cur_q = {};
    nsp = $urandom_range(2, 0);
    for (int i = 0; i < nsp; i++) cur_q.push_back(8'h20);
    sgn = $urandom_range(2, 0);
    if (sgn == 1) cur_q.push_back("-");
    else if (sgn == 2) cur_q.push_back("+");
    nd = $urandom_range(7, 0);
    for (int i = 0; i < nd; i++) cur_q.push_back(8'(8'h30 + $urandom_range(9, 0)));
    if (sgn == 0 && nd == 0) cur_q.push_back(eset[$urandom_range(4, 0)]);
    else cur_q.push_back(tset[$urandom_range(5, 0)]);
  endtask

  initial begin
    reset          = 1'b1;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.num_rdy    = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_char_rdy_low", 32'(bus.char_rdy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_num_valid", 32'(bus.num_valid), 32'd0);
    check("rst_num_out",   32'(bus.num_out),   32'd0);
    check("rst_term_out",  32'(bus.term_out),  32'd0);
    check("rst_errs",      32'({bus.err_empty, bus.err_ovf}), 32'd0);
    check("rst_char_rdy",  32'(bus.char_rdy),  32'd1);

    // Directed cases
    bus.num_rdy = 1'b1;
    load("-123 ");     run_num("neg123", 0, 0);
    load("32767\n");   run_num("max_pos", 0, 0);
    load("-32768,");   run_num("max_neg", 0, 0);
    load("32768 ");    run_num("ovf_pos", 0, 0);
    load("-999999 ");  run_num("ovf_neg", 0, 0);
    load("-X");        run_num("empty_sign", 0, 0);
    load("G");         run_num("empty_bare", 0, 0);
    load("  7;");      run_num("lead_space", 0, 0);
    load("-0 ");       run_num("neg_zero", 0, 0);
    load("42 ");       run_num("backpress", 0, 5);
    load("42 ");       run_num("gaps", 3, 0);

    // Spot-check directed expectations against hand-computed constants
    load("-123 ");
    begin
      logic [15:0] v; logic [7:0] t; logic e, o;
      send_q(0);
      v = bus.num_out; t = bus.term_out; e = bus.err_empty; o = bus.err_ovf;
      check("const_neg123_num",  32'(v), 32'h0000FF85);
      check("const_neg123_term", 32'(t), 32'h20);
      check("const_neg123_errs", 32'({e, o}), 32'd0);
      bus.num_rdy = 1'b1; @(posedge clk); #1; bus.num_rdy = 1'b0;
    end
    load("-999999 ");
    send_q(1);
    check("const_ovf_neg_num", 32'(bus.num_out), 32'h8000);
    check("const_ovf_neg_ovf", 32'(bus.err_ovf), 32'd1);
    bus.num_rdy = 1'b1; @(posedge clk); #1; bus.num_rdy = 1'b0;

    // Reset mid-number discards the partial value
    load("-12");
    send_q(0);
    reset = 1'b1;
    #1;
    check("midrst_char_rdy_low", 32'(bus.char_rdy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_no_valid", 32'(bus.num_valid), 32'd0);
    check("midrst_num_out",  32'(bus.num_out),   32'd0);
    check("midrst_char_rdy", 32'(bus.char_rdy),  32'd1);
    load("5 ");
    send_q(0);
    check("midrst_five", 32'(bus.num_out), 32'd5);
    bus.num_rdy = 1'b1; @(posedge clk); #1; bus.num_rdy = 1'b0;

    // Random numbers with random gaps and result backpressure
    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_num($sformatf("rand%0d", n), 2, $urandom_range(2, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
